pipe_ctrl_unit: RTL and testbench
=================================

Name: pipe_ctrl_unit

Overview:
- Pipelined successor to the combinational MIPS decoder.
- Decodes the ID-stage instruction into a packed control word and carries it, with destination register and exception code, through EX/MEM/WB stage registers.
- Generates load-use and multiply/divide-busy stalls and applies flush bubbles.
- Sits beside the datapath pipeline registers and drives every stage's control.

Parameters:
RA_W, 5, register-address width (dest/src fields)
MULT_CYCLES, 4, EX occupancy of MULT/MULTU (>=1)
DIV_CYCLES, 32, EX occupancy of DIV/DIVU (>=1)
LOAD_USE_STALL, 1, 1 = detect load-use hazard; 0 = never stall for loads (forwarding handled elsewhere)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
id_instr  in  32  instruction in ID
id_valid  in  1  ID instruction valid
flush_id  in  1  kill the ID instruction (branch/jump taken)
stall_out  out  1  hold PC and IF/ID this cycle
ex_cw  out  20  EX control word
mem_cw  out  20  MEM control word
wb_cw  out  20  WB control word
ex_dst / mem_dst / wb_dst  out  RA_W each  destination register per stage (0 = none)
ex_exc  out  4  EX exception code
mdu_busy  out  1  MULT/DIV in progress

Behaviour:
- Control word layout (cw):
  - [3:0] ALUOp: ADD0 SUB1 AND2 OR3 XOR4 NOR5 SLT6 SLTU7 SLL8 SRL9 SRA10 LUI11.
  - [4] ALUSrc, [5] ShamtSrc, [6] Ext_op (1 = sign).
  - [10:7] Branch: bit10 = valid, [9:7] = BEQ0 BNE1 BGEZ2 BGTZ3 BLEZ4 BLTZ5 BGEZAL6 BLTZAL7.
  - [11] Jump, [12] Jr, [13] MemWrite.
  - [15:14] LS: NONE0 WORD1 HALF2 BYTE3; [16] load-unsigned.
  - [17] MemtoReg, [18] RegWrite, [19] MDU op.
- Decode (combinational, ID):
  - R-type, REGIMM (rt 00001/00000/10001/10000), BEQ/BNE/BGTZ/BLEZ, ADDI/ADDIU/ANDI/ORI/XORI/LUI/SLTI/SLTIU, LW/LH/LHU/LB/LBU/SW/SH/SB, J/JAL.
  - ANDI/ORI/XORI zero-extend.
  - Dest: R-type = rd; I-type ALU/loads = rt; JAL/BGEZAL/BLTZAL = 31; others = 0.
  - RegWrite forced 0 when dest = 0.
- Exceptions:
  - SYSCALL (funct 0x0C): exc 8.
  - BREAK (0x0D): exc 9.
  - Undefined opcode/funct/REGIMM rt: exc 10 (reserved instruction), cw = 0.
  - Otherwise exc 0.
- Source use:
  - rs used by all except J/JAL/LUI/shift-immediate.
  - rt used by R-type, BEQ/BNE, stores.
- Load-use stall (LOAD_USE_STALL = 1):
  - Asserted when ex_cw[17] = 1, ex_dst != 0, and ex_dst equals a used ID source, with id_valid.
- MDU counter:
  - When a MULT/MULTU (funct 0x18/0x19) or DIV/DIVU (0x1A/0x1B) enters EX, load MULT_CYCLES-1 or DIV_CYCLES-1.
  - Decrement each cycle to 0; mdu_busy = (counter != 0).
  - While busy, an ID MFHI/MFLO/MTHI/MTLO/MULT*/DIV* stalls.
- stall_out = id_valid & (load-use | mdu hazard) & ~flush_id.
- Clock edge:
  - MEM <- EX and WB <- MEM always advance.
  - EX <- decoded ID if id_valid & ~stall_out & ~flush_id; else EX <- bubble (cw 0, dst 0, exc 0).
  - Priority: flush_id > stall.
- Latency: decode to ex_cw is 1 cycle; to wb_cw is 3 cycles.
- Reset (async, immediate): all cw/dst/exc = 0, counter = 0, mdu_busy = 0, stall_out = 0 combinationally.
- Reset mid-MDU aborts the counter.
- A new MDU op cannot reach EX while busy, so no reload conflict.

Test Plan:
- Reset asserted mid-stream with ex_cw nonzero -> all stage outputs 0 immediately, mdu_busy 0; release -> ADDU $3,$1,$2 (0x00221821) gives ex_cw ALUOp0, RegWrite 1, ex_dst 3 one cycle later.
- LW $5,0($1) then ADD $6,$5,$2 -> stall_out = 1 for exactly 1 cycle, EX holds a bubble, ADD reaches EX next. With LOAD_USE_STALL = 0 -> no stall.
- MULT $1,$2 then MFLO $4 (MULT_CYCLES = 4) -> stall_out high 3 cycles, mdu_busy falls, then MFLO enters EX.
- BGEZAL $1 -> ex_cw Branch = 4'b1110, RegWrite 1, ex_dst 31. Same cycle with flush_id = 1 on the next instruction -> bubble even if a stall is pending.
- Opcode 0x3F -> ex_exc = 10, ex_cw = 0. SYSCALL -> ex_exc = 8.
- Sequence LW/ADDI/SW -> wb_cw matches the decoded word 3 cycles after each ID entry. ADDI to $0 -> RegWrite 0, dst 0.

Source files
------------

// File: rtl/pipe_ctrl_unit_if.sv
// rtl/pipe_ctrl_unit_if.sv - ID inputs and per-stage control outputs of the pipeline control unit

interface pipe_ctrl_unit_if #(
    parameter int RA_W = 5
);
    logic [31:0]     id_instr;
    logic            id_valid;
    logic            flush_id;
    logic            stall_out;
    logic [19:0]     ex_cw;
    logic [19:0]     mem_cw;
    logic [19:0]     wb_cw;
    logic [RA_W-1:0] ex_dst;
    logic [RA_W-1:0] mem_dst;
    logic [RA_W-1:0] wb_dst;
    logic [3:0]      ex_exc;
    logic            mdu_busy;

    modport master (
        output id_instr, id_valid, flush_id,
        input  stall_out, ex_cw, mem_cw, wb_cw, ex_dst, mem_dst, wb_dst, ex_exc, mdu_busy
    );

    modport slave (
        input  id_instr, id_valid, flush_id,
        output stall_out, ex_cw, mem_cw, wb_cw, ex_dst, mem_dst, wb_dst, ex_exc, mdu_busy
    );
endinterface

// File: rtl/pipe_ctrl_unit.sv
// rtl/pipe_ctrl_unit.sv - MIPS ID decode, EX/MEM/WB control pipeline, load-use and MDU stalls

module pipe_ctrl_unit #(
    parameter int RA_W           = 5,
    parameter int MULT_CYCLES    = 4,
    parameter int DIV_CYCLES     = 32,
    parameter int LOAD_USE_STALL = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    pipe_ctrl_unit_if.slave      bus
);
    localparam int MAX_CYC = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    localparam logic [3:0] ALU_ADD = 4'd0,  ALU_SUB = 4'd1,  ALU_AND = 4'd2,  ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_XOR = 4'd4,  ALU_NOR = 4'd5,  ALU_SLT = 4'd6,  ALU_SLTU = 4'd7;
    localparam logic [3:0] ALU_SLL = 4'd8,  ALU_SRL = 4'd9,  ALU_SRA = 4'd10, ALU_LUI = 4'd11;

    logic [5:0]      op, funct;
    logic [RA_W-1:0] rs, rt, rd;

    assign op    = bus.id_instr[31:26];
    assign funct = bus.id_instr[5:0];
    assign rs    = RA_W'(bus.id_instr[25:21]);
    assign rt    = RA_W'(bus.id_instr[20:16]);
    assign rd    = RA_W'(bus.id_instr[15:11]);

    logic [3:0]      alu_op, br;
    logic            alu_src, shamt_src, ext_sign, jmp, jr, mem_wr;
    logic [1:0]      ls;
    logic            ld_uns, mem2reg, reg_wr, mdu_op;
    logic            rs_used, rt_used, mdu_touch, mdu_start, mdu_div, ri;
    logic [3:0]      dec_exc;
    logic [RA_W-1:0] wr_dst, dec_dst;
    logic [19:0]     dec_cw;

    always_comb begin
        alu_op = ALU_ADD; br = 4'd0; alu_src = 1'b0; shamt_src = 1'b0; ext_sign = 1'b0;
        jmp = 1'b0; jr = 1'b0; mem_wr = 1'b0; ls = 2'd0; ld_uns = 1'b0; mem2reg = 1'b0;
        reg_wr = 1'b0; mdu_op = 1'b0; rs_used = 1'b1; rt_used = 1'b0; mdu_touch = 1'b0;
        mdu_start = 1'b0; mdu_div = 1'b0; ri = 1'b0; dec_exc = 4'd0; wr_dst = '0;
        case (op)
            6'h00: begin
                rt_used = 1'b1;
                wr_dst  = rd;
                case (funct)
                    6'h00: begin alu_op = ALU_SLL; shamt_src = 1'b1; reg_wr = 1'b1; rs_used = 1'b0; end
                    6'h02: begin alu_op = ALU_SRL; shamt_src = 1'b1; reg_wr = 1'b1; rs_used = 1'b0; end
                    6'h03: begin alu_op = ALU_SRA; shamt_src = 1'b1; reg_wr = 1'b1; rs_used = 1'b0; end
                    6'h04: begin alu_op = ALU_SLL; reg_wr = 1'b1; end
                    6'h06: begin alu_op = ALU_SRL; reg_wr = 1'b1; end
                    6'h07: begin alu_op = ALU_SRA; reg_wr = 1'b1; end
                    6'h08: jr = 1'b1;
                    6'h09: begin jr = 1'b1; reg_wr = 1'b1; end
                    6'h0C: dec_exc = 4'd8;
                    6'h0D: dec_exc = 4'd9;
                    6'h10, 6'h12: begin mdu_op = 1'b1; mdu_touch = 1'b1; reg_wr = 1'b1; end
                    6'h11, 6'h13: begin mdu_op = 1'b1; mdu_touch = 1'b1; end
                    6'h18, 6'h19: begin mdu_op = 1'b1; mdu_touch = 1'b1; mdu_start = 1'b1; end
                    6'h1A, 6'h1B: begin
                        mdu_op = 1'b1; mdu_touch = 1'b1; mdu_start = 1'b1; mdu_div = 1'b1;
                    end
                    6'h20, 6'h21: begin alu_op = ALU_ADD;  reg_wr = 1'b1; end
                    6'h22, 6'h23: begin alu_op = ALU_SUB;  reg_wr = 1'b1; end
                    6'h24:        begin alu_op = ALU_AND;  reg_wr = 1'b1; end
                    6'h25:        begin alu_op = ALU_OR;   reg_wr = 1'b1; end
                    6'h26:        begin alu_op = ALU_XOR;  reg_wr = 1'b1; end
                    6'h27:        begin alu_op = ALU_NOR;  reg_wr = 1'b1; end
                    6'h2A:        begin alu_op = ALU_SLT;  reg_wr = 1'b1; end
                    6'h2B:        begin alu_op = ALU_SLTU; reg_wr = 1'b1; end
                    default:      ri = 1'b1;
                endcase
            end
            6'h01: begin
                wr_dst = RA_W'(31);
                case (bus.id_instr[20:16])
                    5'b00000: br = 4'b1101;
                    5'b00001: br = 4'b1010;
                    5'b10000: begin br = 4'b1111; reg_wr = 1'b1; end
                    5'b10001: begin br = 4'b1110; reg_wr = 1'b1; end
                    default:  ri = 1'b1;
                endcase
            end
            6'h02: begin jmp = 1'b1; rs_used = 1'b0; end
            6'h03: begin jmp = 1'b1; rs_used = 1'b0; reg_wr = 1'b1; wr_dst = RA_W'(31); end
            6'h04: begin br = 4'b1000; alu_op = ALU_SUB; rt_used = 1'b1; end
            6'h05: begin br = 4'b1001; alu_op = ALU_SUB; rt_used = 1'b1; end
            6'h06: br = 4'b1100;
            6'h07: br = 4'b1011;
            6'h08, 6'h09: begin alu_op = ALU_ADD;  alu_src = 1'b1; ext_sign = 1'b1; reg_wr = 1'b1; wr_dst = rt; end
            6'h0A:        begin alu_op = ALU_SLT;  alu_src = 1'b1; ext_sign = 1'b1; reg_wr = 1'b1; wr_dst = rt; end
            6'h0B:        begin alu_op = ALU_SLTU; alu_src = 1'b1; ext_sign = 1'b1; reg_wr = 1'b1; wr_dst = rt; end
            6'h0C:        begin alu_op = ALU_AND;  alu_src = 1'b1; reg_wr = 1'b1; wr_dst = rt; end
            6'h0D:        begin alu_op = ALU_OR;   alu_src = 1'b1; reg_wr = 1'b1; wr_dst = rt; end
            6'h0E:        begin alu_op = ALU_XOR;  alu_src = 1'b1; reg_wr = 1'b1; wr_dst = rt; end
            6'h0F:        begin alu_op = ALU_LUI;  alu_src = 1'b1; reg_wr = 1'b1; wr_dst = rt; rs_used = 1'b0; end
            6'h20, 6'h21, 6'h23, 6'h24, 6'h25: begin
                alu_src = 1'b1; ext_sign = 1'b1; mem2reg = 1'b1; reg_wr = 1'b1; wr_dst = rt;
                ld_uns  = (op == 6'h24) || (op == 6'h25);
                ls      = (op == 6'h23) ? 2'd1 : ((op == 6'h21 || op == 6'h25) ? 2'd2 : 2'd3);
            end
            6'h28, 6'h29, 6'h2B: begin
                alu_src = 1'b1; ext_sign = 1'b1; mem_wr = 1'b1; rt_used = 1'b1;
                ls      = (op == 6'h2B) ? 2'd1 : ((op == 6'h29) ? 2'd2 : 2'd3);
            end
            default: ri = 1'b1;
        endcase

        // A destination of $0 means the write is discarded, so drop RegWrite too.
        if (wr_dst == '0) reg_wr = 1'b0;
        dec_dst = reg_wr ? wr_dst : '0;
        dec_cw  = {mdu_op, reg_wr, mem2reg, ld_uns, ls, mem_wr, jr, jmp, br,
                   ext_sign, shamt_src, alu_src, alu_op};

        if (ri) begin
            dec_cw = '0; dec_dst = '0; dec_exc = 4'd10;
            rs_used = 1'b0; rt_used = 1'b0; mdu_touch = 1'b0; mdu_start = 1'b0; mdu_div = 1'b0;
        end
    end

    logic [19:0]      ex_cw_q, mem_cw_q, wb_cw_q, ex_cw_d;
    logic [RA_W-1:0]  ex_dst_q, mem_dst_q, wb_dst_q, ex_dst_d;
    logic [3:0]       ex_exc_q, ex_exc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             load_use, mdu_hz, stall, advance;

    assign load_use = (LOAD_USE_STALL != 0) && ex_cw_q[17] && (ex_dst_q != '0) &&
                      ((rs_used && rs == ex_dst_q) || (rt_used && rt == ex_dst_q));
    assign mdu_hz   = (cnt_q != '0) && mdu_touch;
    assign stall    = ~reset & bus.id_valid & (load_use | mdu_hz) & ~bus.flush_id;
    assign advance  = bus.id_valid & ~stall & ~bus.flush_id;

    always_comb begin
        ex_cw_d  = advance ? dec_cw  : '0;
        ex_dst_d = advance ? dec_dst : '0;
        ex_exc_d = advance ? dec_exc : 4'd0;
        cnt_d    = cnt_q;
        if (advance && mdu_start)
            cnt_d = mdu_div ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MULT_CYCLES - 1);
        else if (cnt_q != '0)
            cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_cw_q  <= '0; mem_cw_q  <= '0; wb_cw_q  <= '0;
            ex_dst_q <= '0; mem_dst_q <= '0; wb_dst_q <= '0;
            ex_exc_q <= '0; cnt_q     <= '0;
        end else begin
            ex_cw_q   <= ex_cw_d;
            ex_dst_q  <= ex_dst_d;
            ex_exc_q  <= ex_exc_d;
            mem_cw_q  <= ex_cw_q;
            mem_dst_q <= ex_dst_q;
            wb_cw_q   <= mem_cw_q;
            wb_dst_q  <= mem_dst_q;
            cnt_q     <= cnt_d;
        end
    end

    assign bus.stall_out = stall;
    assign bus.ex_cw     = ex_cw_q;
    assign bus.mem_cw    = mem_cw_q;
    assign bus.wb_cw     = wb_cw_q;
    assign bus.ex_dst    = ex_dst_q;
    assign bus.mem_dst   = mem_dst_q;
    assign bus.wb_dst    = wb_dst_q;
    assign bus.ex_exc    = ex_exc_q;
    assign bus.mdu_busy  = (cnt_q != '0);
endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// tb/tb_pipe_ctrl_unit.sv - directed self-checking bench for pipe_ctrl_unit

module tb_pipe_ctrl_unit;
    localparam logic [31:0] I_ADDU   = 32'h00221821;
    localparam logic [31:0] I_LW     = 32'h8C250000;
    localparam logic [31:0] I_ADD    = 32'h00A23020;
    localparam logic [31:0] I_MULT   = 32'h00220018;
    localparam logic [31:0] I_MFLO   = 32'h00002012;
    localparam logic [31:0] I_BGEZAL = 32'h04310000;
    localparam logic [31:0] I_ADDI7  = 32'h20270005;
    localparam logic [31:0] I_SW     = 32'hAC270004;
    localparam logic [31:0] I_ADDI0  = 32'h20200001;
    localparam logic [31:0] I_RSVD   = 32'hFC000000;
    localparam logic [31:0] I_SYS    = 32'h0000000C;

    localparam logic [31:0] CW_ADDU = 32'h40000;
    localparam logic [31:0] CW_LW   = 32'h64050;
    localparam logic [31:0] CW_MULT = 32'h80000;
    localparam logic [31:0] CW_MFLO = 32'hC0000;
    localparam logic [31:0] CW_BGZL = 32'h40700;
    localparam logic [31:0] CW_ADDI = 32'h40050;
    localparam logic [31:0] CW_SW   = 32'h06050;
    localparam logic [31:0] CW_ADI0 = 32'h00050;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    pipe_ctrl_unit_if #(.RA_W(5)) bus0 ();
    pipe_ctrl_unit_if #(.RA_W(5)) bus1 ();

    assign bus1.id_instr = bus0.id_instr;
    assign bus1.id_valid = bus0.id_valid;
    assign bus1.flush_id = bus0.flush_id;

    pipe_ctrl_unit #(.RA_W(5), .MULT_CYCLES(4), .DIV_CYCLES(32), .LOAD_USE_STALL(1)) u_dut (
        .clk(clk), .reset(reset), .bus(bus0)
    );
    pipe_ctrl_unit #(.RA_W(5), .MULT_CYCLES(4), .DIV_CYCLES(32), .LOAD_USE_STALL(0)) u_dut_nolu (
        .clk(clk), .reset(reset), .bus(bus1)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [31:0] ins, input logic v, input logic f);
        @(negedge clk);
        bus0.id_instr = ins;
        bus0.id_valid = v;
        bus0.flush_id = f;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        bus0.id_instr = 32'h0;
        bus0.id_valid = 1'b0;
        bus0.flush_id = 1'b0;
        #1;
        check_eq("rst_ex_cw", 32'(bus0.ex_cw), 32'h0);
        check_eq("rst_wb_cw", 32'(bus0.wb_cw), 32'h0);
        check_eq("rst_busy",  32'(bus0.mdu_busy), 32'h0);
        check_eq("rst_stall", 32'(bus0.stall_out), 32'h0);
        @(negedge clk);
        reset = 1'b0;

        drive(I_MULT, 1'b1, 1'b0); tick();
        check_eq("mult_ex_cw", 32'(bus0.ex_cw), CW_MULT);
        check_eq("mult_busy",  32'(bus0.mdu_busy), 32'h1);
        drive(I_ADDU, 1'b1, 1'b0); tick();
        check_eq("addu_pre_ex", 32'(bus0.ex_cw), CW_ADDU);
        @(negedge clk);
        reset = 1'b1;
        bus0.id_valid = 1'b0;
        #1;
        check_eq("midrst_ex_cw",  32'(bus0.ex_cw), 32'h0);
        check_eq("midrst_mem_cw", 32'(bus0.mem_cw), 32'h0);
        check_eq("midrst_ex_dst", 32'(bus0.ex_dst), 32'h0);
        check_eq("midrst_busy",   32'(bus0.mdu_busy), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        drive(I_ADDU, 1'b1, 1'b0); tick();
        check_eq("addu_ex_cw",  32'(bus0.ex_cw), CW_ADDU);
        check_eq("addu_ex_dst", 32'(bus0.ex_dst), 32'd3);
        check_eq("addu_ex_exc", 32'(bus0.ex_exc), 32'd0);

        drive(I_LW, 1'b1, 1'b0); tick();
        check_eq("lw_ex_cw",  32'(bus0.ex_cw), CW_LW);
        check_eq("lw_ex_dst", 32'(bus0.ex_dst), 32'd5);
        drive(I_ADD, 1'b1, 1'b0); #1;
        check_eq("lu_stall",      32'(bus0.stall_out), 32'h1);
        check_eq("lu_stall_off",  32'(bus1.stall_out), 32'h0);
        tick();
        check_eq("lu_bubble",     32'(bus0.ex_cw), 32'h0);
        check_eq("lu_mem_lw",     32'(bus0.mem_cw), CW_LW);
        check_eq("lu_off_ex_add", 32'(bus1.ex_cw), CW_ADDU);
        drive(I_ADD, 1'b1, 1'b0); #1;
        check_eq("lu_stall_end", 32'(bus0.stall_out), 32'h0);
        tick();
        check_eq("add_ex_cw",  32'(bus0.ex_cw), CW_ADDU);
        check_eq("add_ex_dst", 32'(bus0.ex_dst), 32'd6);
        drive(32'h0, 1'b0, 1'b0); tick();

        drive(I_MULT, 1'b1, 1'b0); tick();
        for (int i = 0; i < 3; i++) begin
            drive(I_MFLO, 1'b1, 1'b0); #1;
            check_eq($sformatf("mdu_stall%0d", i), 32'(bus0.stall_out), 32'h1);
            check_eq($sformatf("mdu_busy%0d", i),  32'(bus0.mdu_busy), 32'h1);
            tick();
            check_eq($sformatf("mdu_bubble%0d", i), 32'(bus0.ex_cw), 32'h0);
        end
        drive(I_MFLO, 1'b1, 1'b0); #1;
        check_eq("mdu_stall_end", 32'(bus0.stall_out), 32'h0);
        check_eq("mdu_busy_end",  32'(bus0.mdu_busy), 32'h0);
        tick();
        check_eq("mflo_ex_cw",  32'(bus0.ex_cw), CW_MFLO);
        check_eq("mflo_ex_dst", 32'(bus0.ex_dst), 32'd4);

        drive(I_BGEZAL, 1'b1, 1'b0); tick();
        check_eq("bgezal_ex_cw",  32'(bus0.ex_cw), CW_BGZL);
        check_eq("bgezal_ex_dst", 32'(bus0.ex_dst), 32'd31);

        drive(I_LW, 1'b1, 1'b0); tick();
        drive(I_ADD, 1'b1, 1'b1); #1;
        check_eq("flush_stall", 32'(bus0.stall_out), 32'h0);
        tick();
        check_eq("flush_ex_cw",  32'(bus0.ex_cw), 32'h0);
        check_eq("flush_ex_dst", 32'(bus0.ex_dst), 32'h0);

        drive(I_RSVD, 1'b1, 1'b0); tick();
        check_eq("rsvd_ex_exc", 32'(bus0.ex_exc), 32'd10);
        check_eq("rsvd_ex_cw",  32'(bus0.ex_cw), 32'h0);
        drive(I_SYS, 1'b1, 1'b0); tick();
        check_eq("sys_ex_exc", 32'(bus0.ex_exc), 32'd8);
        drive(I_ADDI0, 1'b1, 1'b0); tick();
        check_eq("addi0_ex_cw",  32'(bus0.ex_cw), CW_ADI0);
        check_eq("addi0_ex_dst", 32'(bus0.ex_dst), 32'd0);

        drive(I_LW, 1'b1, 1'b0); tick();
        drive(I_ADDI7, 1'b1, 1'b0); #1;
        check_eq("addi_no_stall", 32'(bus0.stall_out), 32'h0);
        tick();
        drive(I_SW, 1'b1, 1'b0); #1;
        check_eq("sw_no_stall", 32'(bus0.stall_out), 32'h0);
        tick();
        check_eq("p3_ex_cw",  32'(bus0.ex_cw), CW_SW);
        check_eq("p3_mem_cw", 32'(bus0.mem_cw), CW_ADDI);
        check_eq("p3_wb_cw",  32'(bus0.wb_cw), CW_LW);
        check_eq("p3_wb_dst", 32'(bus0.wb_dst), 32'd5);
        drive(32'h0, 1'b0, 1'b0); tick();
        check_eq("p4_wb_cw",  32'(bus0.wb_cw), CW_ADDI);
        check_eq("p4_wb_dst", 32'(bus0.wb_dst), 32'd7);
        check_eq("p4_mem_dst", 32'(bus0.mem_dst), 32'd0);
        tick();
        check_eq("p5_wb_cw",  32'(bus0.wb_cw), CW_SW);
        check_eq("p5_wb_dst", 32'(bus0.wb_dst), 32'd0);
        check_eq("p5_ex_cw",  32'(bus0.ex_cw), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
